// File: rtl/lsu_pkg.sv
// ----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit:
//   - RV32I funct3 width/sign codes used by loads and stores
//   - lsu_state_t, the controller FSM state encoding
//   - request legality helpers (funct3 legality, alignment)
//   - load_extract / store_merge, the little-endian sub-word datapath
// ----------------------------------------------------------------------------
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_WAIT  = 3'd1,
    ST_RMW_WAIT = 3'd2,
    ST_RMW_WR   = 3'd3,
    ST_RESP     = 3'd4
  } lsu_state_t;

  // Stores only have signed-style codes; BU/HU are load-only.
  function automatic logic f3_legal(input logic we, input logic [2:0] funct3);
    logic r;
    case (funct3)
      F3_B, F3_H, F3_W: r = 1'b1;
      F3_BU, F3_HU:     r = ~we;
      default:          r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic r;
    case (funct3)
      F3_H, F3_HU: r = addr_lo[0];
      F3_W:        r = (addr_lo != 2'b00);
      default:     r = 1'b0;
    endcase
    return r;
  endfunction

  // Little-endian extraction: byte picked by addr_lo, half by addr_lo[1].
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  addr_lo,
                                               input logic [2:0]  funct3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (addr_lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_W:    r = word;
      F3_BU:   r = {24'h000000, b};
      F3_HU:   r = {16'h0000, h};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Replace only the addressed byte/half of old_word with the low bits of wdata.
  function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  addr_lo,
                                              input logic [2:0]  funct3);
    logic [31:0] r;
    r = old_word;
    case (funct3)
      F3_B: begin
        case (addr_lo)
          2'd0:    r[7:0]   = wdata[7:0];
          2'd1:    r[15:8]  = wdata[7:0];
          2'd2:    r[23:16] = wdata[7:0];
          default: r[31:24] = wdata[7:0];
        endcase
      end
      F3_H: begin
        if (addr_lo[1]) begin
          r[31:16] = wdata[15:0];
        end else begin
          r[15:0] = wdata[15:0];
        end
      end
      F3_W:    r = wdata;
      default: r = old_word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// ----------------------------------------------------------------------------
// lsu_align
// Combinational sub-word datapath shared by the memory controller (and a
// future cache path).
// Ports:
//   i_word       32  word read from memory
//   i_wdata      32  right-aligned store data
//   i_addr_lo     2  byte offset within the word
//   i_funct3      3  RV32I width/sign code
//   o_load_data  32  extended load result
//   o_store_word 32  i_word with the addressed byte/half replaced
// ----------------------------------------------------------------------------
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_load_data,
  output logic [31:0] o_store_word
);

  assign o_load_data  = load_extract(i_word, i_addr_lo, i_funct3);
  assign o_store_word = store_merge(i_word, i_wdata, i_addr_lo, i_funct3);

endmodule

// File: rtl/lsu_mem_ctrl.sv
// ----------------------------------------------------------------------------
// lsu_mem_ctrl
// Load/store unit between the execute stage and a word-organised DataMemory
// without byte enables. Sub-word stores are read-modify-write.
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_we, req_funct3         store flag and RV32I width/sign code
//   req_addr, req_wdata        byte address, right-aligned store data
//   resp_valid/rdata/err       one-cycle completion pulse with result
//   mem_address                word-aligned byte address to DataMemory
//   mem_write_data/enable      full-word write strobe
//   mem_read_enable            read strobe
//   mem_read_data              word from DataMemory, MEM_RD_LAT cycles later
// Timing (accept edge = edge 0): error resp at edge 1, SW write in the cycle
// after accept with resp at edge 1, load resp at edge MEM_RD_LAT+1, SB/SH
// resp at edge MEM_RD_LAT+2.
// ----------------------------------------------------------------------------
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS  = 256,
  parameter int MEM_RD_LAT = 1
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable,
  output logic        mem_read_enable,
  input  logic [31:0] mem_read_data
);

  localparam int              CNT_W     = (MEM_RD_LAT > 0) ? $clog2(MEM_RD_LAT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_RD_LAT);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // One extra bit so MEM_WORDS*4 never wraps for a full 4 GiB map.
  localparam logic [32:0]      MEM_BYTES = 33'(MEM_WORDS) * 33'd4;

  lsu_state_t       r_state;
  lsu_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic [2:0]       r_funct3;
  logic [1:0]       r_addr_lo;
  logic [31:0]      r_wdata;

  logic [31:0]      r_mem_address;
  logic [31:0]      r_mem_wdata;
  logic             r_mem_we;
  logic             r_mem_re;
  logic             r_resp_valid;
  logic             r_resp_err;
  logic [31:0]      r_resp_rdata;
  logic             r_req_ready;

  logic [31:0]      w_mem_wdata_nxt;
  logic             w_mem_we_nxt;
  logic             w_mem_re_nxt;
  logic             w_resp_valid_nxt;
  logic             w_resp_err_nxt;
  logic [31:0]      w_resp_rdata_nxt;
  logic             w_accept;
  logic             w_req_err;
  logic [31:0]      w_load_data;
  logic [31:0]      w_store_word;

  // Rejection is decided from the raw request so no strobe is ever issued.
  assign w_req_err = ~f3_legal(req_we, req_funct3)
                   | misaligned(req_funct3, req_addr[1:0])
                   | ({1'b0, req_addr} >= MEM_BYTES);

  lsu_align u_align (
    .i_word       (mem_read_data),
    .i_wdata      (r_wdata),
    .i_addr_lo    (r_addr_lo),
    .i_funct3     (r_funct3),
    .o_load_data  (w_load_data),
    .o_store_word (w_store_word)
  );

  // Next-state and next-output logic; all outputs are registered from these.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_accept         = 1'b0;
    w_mem_re_nxt     = 1'b0;
    w_mem_we_nxt     = 1'b0;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_resp_valid_nxt = 1'b0;
    w_resp_err_nxt   = 1'b0;
    w_resp_rdata_nxt = 32'h0000_0000;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          if (w_req_err) begin
            w_state_nxt = ST_RESP;
          end else if (req_we && (req_funct3 == F3_W)) begin
            // Full-word store needs no read; write directly from the request.
            w_state_nxt     = ST_RMW_WR;
            w_mem_we_nxt    = 1'b1;
            w_mem_wdata_nxt = req_wdata;
          end else if (req_we) begin
            w_state_nxt  = ST_RMW_WAIT;
            w_mem_re_nxt = 1'b1;
            w_cnt_nxt    = CNT_LOAD;
          end else begin
            w_state_nxt  = ST_RD_WAIT;
            w_mem_re_nxt = 1'b1;
            w_cnt_nxt    = CNT_LOAD;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        if (r_cnt == CNT_ZERO) begin
          w_resp_valid_nxt = 1'b1;
          w_resp_rdata_nxt = w_load_data;
          w_state_nxt      = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      ST_RMW_WAIT: begin
        if (r_cnt == CNT_ZERO) begin
          w_mem_we_nxt    = 1'b1;
          w_mem_wdata_nxt = w_store_word;
          w_state_nxt     = ST_RMW_WR;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      ST_RMW_WR: begin
        // Write strobe is high during this state; respond on the edge that
        // commits the write.
        w_resp_valid_nxt = 1'b1;
        w_state_nxt      = ST_IDLE;
      end
      ST_RESP: begin
        // Only rejected requests pass through RESP.
        w_resp_valid_nxt = 1'b1;
        w_resp_err_nxt   = 1'b1;
        w_state_nxt      = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state, latency counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= CNT_ZERO;
      r_mem_wdata  <= 32'h0000_0000;
      r_mem_we     <= 1'b0;
      r_mem_re     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'h0000_0000;
      r_req_ready  <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_re     <= w_mem_re_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_err   <= w_resp_err_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_req_ready  <= (w_state_nxt == ST_IDLE);
    end
  end

  // Request capture at accept; the address is held for the whole access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_funct3      <= 3'b000;
      r_addr_lo     <= 2'b00;
      r_wdata       <= 32'h0000_0000;
      r_mem_address <= 32'h0000_0000;
    end else if (w_accept) begin
      r_funct3      <= req_funct3;
      r_addr_lo     <= req_addr[1:0];
      r_wdata       <= req_wdata;
      r_mem_address <= {req_addr[31:2], 2'b00};
    end else begin
      r_funct3      <= r_funct3;
      r_addr_lo     <= r_addr_lo;
      r_wdata       <= r_wdata;
      r_mem_address <= r_mem_address;
    end
  end

  assign req_ready        = r_req_ready;
  assign resp_valid       = r_resp_valid;
  assign resp_rdata       = r_resp_rdata;
  assign resp_err         = r_resp_err;
  assign mem_address      = r_mem_address;
  assign mem_write_data   = r_mem_wdata;
  assign mem_write_enable = r_mem_we;
  assign mem_read_enable  = r_mem_re;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// ----------------------------------------------------------------------------
// tb_lsu_mem_ctrl
// Three instances of lsu_mem_ctrl (MEM_RD_LAT = 0, 1, 2) share one request
// stream; each has its own DataMemory model. A word-array reference model
// predicts error, load data, memory contents and response latency.
// ----------------------------------------------------------------------------
module tb_lsu_mem_ctrl;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_clr;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        m_ready  [NI];
  logic        m_rvalid [NI];
  logic [31:0] m_rdata  [NI];
  logic        m_err    [NI];
  logic [31:0] m_addr   [NI];
  logic [31:0] m_wdata  [NI];
  logic        m_we     [NI];
  logic        m_re     [NI];
  logic [31:0] m_rd     [NI];

  logic [31:0] dmem [NI][256];
  logic [31:0] s1   [NI];
  logic [31:0] s2   [NI];
  logic [31:0] ref_mem [256];
  logic [31:0] got_rdata [NI];

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    lsu_mem_ctrl #(.MEM_WORDS(256), .MEM_RD_LAT(g)) u_dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .req_valid        (req_valid),
      .req_ready        (m_ready[g]),
      .req_we           (req_we),
      .req_funct3       (req_funct3),
      .req_addr         (req_addr),
      .req_wdata        (req_wdata),
      .resp_valid       (m_rvalid[g]),
      .resp_rdata       (m_rdata[g]),
      .resp_err         (m_err[g]),
      .mem_address      (m_addr[g]),
      .mem_write_data   (m_wdata[g]),
      .mem_write_enable (m_we[g]),
      .mem_read_enable  (m_re[g]),
      .mem_read_data    (m_rd[g])
    );
  end

  // DataMemory models: write on the edge ending the strobe cycle, read data
  // valid 0/1/2 cycles after the read-enable cycle.
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (mem_clr) begin
        for (int i = 0; i < 256; i++) dmem[k][i] <= 32'h0;
      end else if (m_we[k]) begin
        dmem[k][m_addr[k][9:2]] <= m_wdata[k];
      end
      if (m_re[k]) s1[k] <= dmem[k][m_addr[k][9:2]];
      s2[k] <= s1[k];
    end
  end

  always_comb begin
    m_rd[0] = dmem[0][m_addr[0][9:2]];
    m_rd[1] = s1[1];
    m_rd[2] = s2[2];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] size_of(input bit [2:0] f3);
    if (f3[1:0] == 2'd0) return 32'd1;
    else if (f3[1:0] == 2'd1) return 32'd2;
    else return 32'd4;
  endfunction

  function automatic bit model_err(input bit we, input bit [2:0] f3, input logic [31:0] addr);
    bit legal;
    if (we) legal = (f3 <= 3'd2);
    else legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    if (!legal) return 1'b1;
    if ((addr % size_of(f3)) != 32'd0) return 1'b1;
    return (addr >= 32'd1024);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] addr,
                                             input bit [2:0] f3);
    logic [31:0] sh, v, sz;
    sz = size_of(f3);
    sh = (addr % 32'd4) * 32'd8;
    if (sz == 32'd4) return word;
    v = (word >> sh) & ((sz == 32'd1) ? 32'h0000_00FF : 32'h0000_FFFF);
    if (!f3[2] && sz == 32'd1 && v >= 32'd128) v = v | 32'hFFFF_FF00;
    if (!f3[2] && sz == 32'd2 && v >= 32'd32768) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [31:0] addr, input bit [2:0] f3);
    logic [31:0] sh, mask, sz;
    sz = size_of(f3);
    sh = (addr % 32'd4) * 32'd8;
    mask = (sz == 32'd1) ? 32'h0000_00FF : (sz == 32'd2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    mask = mask << sh;
    return (old & ~mask) | ((wd << sh) & mask);
  endfunction

  // Issue one request (called just after a rising edge) and follow all
  // instances until each has responded or the cycle budget runs out.
  task automatic do_req(input bit we, input bit [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd);
    bit          e, wr, all_done;
    logic [31:0] exp_rd, exp_word;
    int          idx;
    int          exp_lat [NI];
    int          lat     [NI];
    bit          done    [NI];
    int          nre     [NI];
    int          nwe     [NI];
    int          nboth   [NI];
    e        = model_err(we, f3, addr);
    idx      = int'(addr[9:2]);
    wr       = !e && we;
    exp_rd   = (e || we) ? 32'h0 : model_load(ref_mem[idx], addr, f3);
    exp_word = wr ? model_store(ref_mem[idx], wd, addr, f3) : ref_mem[idx];
    for (int k = 0; k < NI; k++) begin
      exp_lat[k] = e ? 1 : (we && f3 == 3'd2) ? 1 : we ? k + 2 : k + 1;
      lat[k] = 0; done[k] = 1'b0; nre[k] = 0; nwe[k] = 0; nboth[k] = 0;
      check_val($sformatf("L%0d ready_before_req", k), 32'(m_ready[k]), 32'd1);
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    all_done = 1'b0;
    for (int n = 1; n <= 24 && !all_done; n++) begin
      for (int k = 0; k < NI; k++) begin
        if (!done[k]) begin
          if (m_re[k]) begin
            nre[k]++;
            check_val($sformatf("L%0d rd_addr", k), m_addr[k], {addr[31:2], 2'b00});
          end
          if (m_we[k]) begin
            nwe[k]++;
            check_val($sformatf("L%0d wr_addr", k), m_addr[k], {addr[31:2], 2'b00});
            check_val($sformatf("L%0d wr_data", k), m_wdata[k], exp_word);
          end
          if (m_re[k] && m_we[k]) nboth[k]++;
        end
      end
      @(posedge clk); #1;
      all_done = 1'b1;
      for (int k = 0; k < NI; k++) begin
        if (!done[k] && m_rvalid[k]) begin
          done[k] = 1'b1;
          lat[k] = n;
          got_rdata[k] = m_rdata[k];
          check_val($sformatf("L%0d rdata a=%08h f3=%0d", k, addr, f3), m_rdata[k], exp_rd);
          check_val($sformatf("L%0d err a=%08h f3=%0d we=%0d", k, addr, f3, we),
                    32'(m_err[k]), 32'(e));
          check_val($sformatf("L%0d ready_with_resp", k), 32'(m_ready[k]), 32'd1);
        end
        all_done = all_done && done[k];
      end
    end
    for (int k = 0; k < NI; k++) begin
      check_val($sformatf("L%0d resp_seen", k), 32'(done[k]), 32'd1);
      check_val($sformatf("L%0d latency a=%08h f3=%0d we=%0d", k, addr, f3, we),
                32'(lat[k]), 32'(exp_lat[k]));
      check_val($sformatf("L%0d n_read_strobes", k), 32'(nre[k]),
                (e || (we && f3 == 3'd2)) ? 32'd0 : 32'd1);
      check_val($sformatf("L%0d n_write_strobes", k), 32'(nwe[k]), 32'(wr));
      check_val($sformatf("L%0d strobes_overlap", k), 32'(nboth[k]), 32'd0);
      if (wr) check_val($sformatf("L%0d mem_word", k), dmem[k][idx], exp_word);
    end
    if (wr) ref_mem[idx] = exp_word;
  endtask

  bit          r_we;
  bit [2:0]    r_f3;
  logic [31:0] r_a;
  logic [31:0] pre;
  int          r_sel;
  int          n_spurious;

  initial begin
    rst_n = 1'b0; mem_clr = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      check_val($sformatf("L%0d rst_ready", k), 32'(m_ready[k]), 32'd1);
      check_val($sformatf("L%0d rst_resp_valid", k), 32'(m_rvalid[k]), 32'd0);
      check_val($sformatf("L%0d rst_resp_err", k), 32'(m_err[k]), 32'd0);
      check_val($sformatf("L%0d rst_resp_rdata", k), m_rdata[k], 32'd0);
      check_val($sformatf("L%0d rst_mem_we", k), 32'(m_we[k]), 32'd0);
      check_val($sformatf("L%0d rst_mem_re", k), 32'(m_re[k]), 32'd0);
      check_val($sformatf("L%0d rst_mem_addr", k), m_addr[k], 32'd0);
      check_val($sformatf("L%0d rst_mem_wdata", k), m_wdata[k], 32'd0);
    end
    mem_clr = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Stores, loads, byte and halfword RMW.
    do_req(1'b1, 3'd2, 32'h04, 32'hDEAD_BEEF);
    do_req(1'b0, 3'd2, 32'h04, 32'h0);
    check_val("tp_lw", got_rdata[1], 32'hDEAD_BEEF);
    do_req(1'b1, 3'd2, 32'h08, 32'hCAFE_BABE);
    do_req(1'b1, 3'd0, 32'h09, 32'h1234_56AA);
    check_val("tp_sb_word", dmem[1][2], 32'hCAFE_AABE);
    do_req(1'b0, 3'd4, 32'h09, 32'h0);
    check_val("tp_lbu", got_rdata[1], 32'h0000_00AA);
    do_req(1'b0, 3'd0, 32'h09, 32'h0);
    check_val("tp_lb", got_rdata[1], 32'hFFFF_FFAA);
    do_req(1'b1, 3'd2, 32'h08, 32'hCAFE_BABE);
    do_req(1'b1, 3'd1, 32'h0A, 32'h0000_1234);
    check_val("tp_sh_word", dmem[2][2], 32'h1234_BABE);
    do_req(1'b0, 3'd1, 32'h06, 32'h0);
    check_val("tp_lh", got_rdata[0], 32'hFFFF_DEAD);
    do_req(1'b0, 3'd5, 32'h06, 32'h0);
    check_val("tp_lhu", got_rdata[2], 32'h0000_DEAD);

    // Rejected requests and range boundary.
    do_req(1'b0, 3'd2, 32'h06, 32'h0);
    do_req(1'b1, 3'd1, 32'h03, 32'h5555_5555);
    do_req(1'b0, 3'd3, 32'h00, 32'h0);
    do_req(1'b0, 3'd2, 32'h400, 32'h0);
    do_req(1'b1, 3'd4, 32'h10, 32'h7777_7777);
    do_req(1'b1, 3'd2, 32'h3FC, 32'h0BAD_F00D);
    do_req(1'b0, 3'd2, 32'h3FC, 32'h0);
    check_val("tp_last_word", got_rdata[0], 32'h0BAD_F00D);

    // Back-to-back SW then LW.
    do_req(1'b1, 3'd2, 32'h10, 32'h1357_9BDF);
    do_req(1'b0, 3'd2, 32'h10, 32'h0);
    check_val("tp_b2b", got_rdata[1], 32'h1357_9BDF);

    // Reset during the read phase of an SB.
    do_req(1'b1, 3'd2, 32'h20, 32'h5566_7788);
    pre = ref_mem[8];
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h21; req_wdata = 32'hAB;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 0; k < NI; k++)
      check_val($sformatf("L%0d sb_read_started", k), 32'(m_re[k]), 32'd1);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      check_val($sformatf("L%0d midrst_re", k), 32'(m_re[k]), 32'd0);
      check_val($sformatf("L%0d midrst_we", k), 32'(m_we[k]), 32'd0);
      check_val($sformatf("L%0d midrst_resp", k), 32'(m_rvalid[k]), 32'd0);
      check_val($sformatf("L%0d midrst_ready", k), 32'(m_ready[k]), 32'd1);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    n_spurious = 0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      for (int k = 0; k < NI; k++)
        if (m_rvalid[k] || m_we[k] || m_re[k]) n_spurious++;
    end
    check_val("midrst_spurious_activity", 32'(n_spurious), 32'd0);
    for (int k = 0; k < NI; k++) begin
      check_val($sformatf("L%0d midrst_mem_kept", k), dmem[k][8], pre);
      check_val($sformatf("L%0d post_rst_ready", k), 32'(m_ready[k]), 32'd1);
    end

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      r_we = 1'($urandom_range(0, 1));
      r_sel = int'($urandom_range(0, 9));
      case (r_sel)
        0:       r_f3 = 3'($urandom_range(0, 7));
        1, 2:    r_f3 = 3'd0;
        3, 4:    r_f3 = 3'd1;
        5, 6:    r_f3 = 3'd2;
        7:       r_f3 = 3'd4;
        default: r_f3 = 3'd5;
      endcase
      r_sel = int'($urandom_range(0, 15));
      if (r_sel == 0) r_a = $urandom;
      else if (r_sel == 1) r_a = 32'd1016 + 32'($urandom_range(0, 15));
      else r_a = 32'($urandom_range(0, 63));
      if (r_sel >= 2 && r_sel < 12) r_a = r_a & ~(size_of(r_f3) - 32'd1);
      do_req(r_we, r_f3, r_a, $urandom);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store unit that sits between the RISC-V core's execute stage and the word-organised DataMemory (clk, address, write_data, write_enable, read_enable, read_data).
- Handles RV32I LB/LH/LW/LBU/LHU/SB/SH/SW.
- Performs byte/halfword extraction with sign or zero extension.
- DataMemory has no byte enables, so sub-word stores are done as read-modify-write.
- Flags misaligned, out-of-range and illegal accesses without touching memory.

Parameters:
MEM_WORDS, 256, number of 32-bit words in DataMemory; valid byte addresses are 0 .. MEM_WORDS*4-1.
MEM_RD_LAT, 1, cycles from the cycle mem_read_enable is high until mem_read_data is valid (0 = combinational read).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  1  core request valid.
req_ready  output  1  unit can accept a request (high only in IDLE).
req_we  input  1  1 = store, 0 = load.
req_funct3  input  3  RV32I funct3 width/sign code.
req_addr  input  32  byte address.
req_wdata  input  32  store data, right-aligned.
resp_valid  output  1  one-cycle completion pulse.
resp_rdata  output  32  extended load data; 0 for stores and errors.
resp_err  output  1  access rejected; qualified by resp_valid.
mem_address  output  32  word-aligned byte address to DataMemory.
mem_write_data  output  32  full word to write.
mem_write_enable  output  1  write strobe; memory writes on the rising edge ending the cycle.
mem_read_enable  output  1  read strobe.
mem_read_data  input  32  word from DataMemory.

Behaviour:
- Clock, reset and interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - All outputs 0, except req_ready = 1.
  - State = IDLE and the latency counter is cleared.
  - Reset mid-operation drops the pending access. mem_write_enable falls immediately, so no partial RMW write occurs and no resp_valid is produced.
- Accept: a request is accepted on a rising edge with req_valid && req_ready. At accept, addr, we, funct3 and wdata are registered. req_ready = (state == IDLE).
- Encodings:
  - Valid load funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
  - Valid store funct3: 000 B, 001 H, 010 W.
  - Any other encoding is an error.
- Error check, evaluated at accept. The request is an error if any of the following holds:
  - illegal funct3;
  - H/HU with addr[0] = 1;
  - W with addr[1:0] != 0;
  - addr >= MEM_WORDS*4.
  On error: go to RESP with no memory strobes. resp_valid = 1 and resp_err = 1 on the next edge; resp_rdata = 0.
- States: IDLE, RD_WAIT, RMW_WAIT, RMW_WR, RESP.
- SW:
  - On the edge after accept: mem_write_enable = 1 for exactly one cycle, with mem_address = {addr[31:2], 2'b00} and mem_write_data = wdata.
  - resp_valid follows 1 edge after the write cycle.
- Loads:
  - mem_read_enable = 1 for one cycle; the counter is loaded with MEM_RD_LAT.
  - RD_WAIT samples mem_read_data when the counter reaches 0.
  - resp_valid is asserted MEM_RD_LAT+1 edges after accept.
  - Extraction is little-endian. The byte is selected by addr[1:0] and the half by addr[1]. B/H sign-extend; BU/HU zero-extend.
- SB/SH:
  - Read phase as for a load (RMW_WAIT).
  - On the sample edge, enter RMW_WR: mem_write_enable = 1 for one cycle with the merged word. Only the addressed byte or half is replaced by wdata[7:0] or wdata[15:0].
  - resp_valid follows on the next edge; the total is MEM_RD_LAT+2 edges after accept.
- Strobes: mem_read_enable and mem_write_enable are never high together. Each is high for exactly one cycle per access. mem_address is held for the whole access.
- RESP: resp_valid is a single-cycle pulse with no backpressure. The state returns to IDLE on the same edge, so req_ready is high concurrently and back-to-back requests are legal.

Decomposition:
- Package lsu_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - lsu_state_t enum;
  - functions load_extract(word, addr_lo, funct3) and store_merge(old_word, wdata, addr_lo, funct3).
- Sub-module lsu_align: combinational extract/merge built on the package functions. It is reused by a future cache path.
- lsu_mem_ctrl holds the FSM, the registered request and the latency counter.

Test Plan:
1. Stores and loads (MEM_RD_LAT=1):
   - SW 0xDEADBEEF @0x04 -> one write cycle, mem_address 0x04, data DEADBEEF; resp_valid 1 edge later, resp_err 0.
   - LW @0x04 -> resp_rdata 0xDEADBEEF 2 edges after accept.
2. Byte RMW, with word 0x08 = 0xCAFEBABE:
   - SB 0x123456AA @0x09 -> read then write 0xCAFEAABE, resp after 3 edges.
   - Then LBU @0x09 -> 0x000000AA and LB @0x09 -> 0xFFFFFFAA.
3. Halfwords:
   - SH 0x00001234 @0x0A over 0xCAFEBABE -> memory 0x1234BABE.
   - LH @0x06 over 0xDEADBEEF -> 0xFFFFDEAD; LHU @0x06 -> 0x0000DEAD.
4. Errors:
   - LW @0x06, SH @0x03, funct3=011 load, and LW @0x400 -> each gives resp_err 1 and resp_rdata 0, 1 edge after accept, with no mem strobes.
5. Back-to-back and reset:
   - SW then LW on consecutive req_ready cycles -> LW returns the new data.
   - rst_n low during RMW_WAIT of an SB -> strobes 0 immediately, memory unchanged, no resp_valid, req_ready 1 after release.
6. Latency variant: MEM_RD_LAT=2 -> LW resp 3 edges after accept, SB resp 4 edges after accept; MEM_RD_LAT=0 -> LW resp after 1 edge.
